// File: rtl/piso_8_bit.sv
// Parallel-in, serial-out shift register: load a word, then stream it out one
// bit per clock with zero fill, from the MSB or the LSB end.
module piso_8_bit #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,        // active-high synchronous reset
  input  logic             sel_p_s,      // 0 = parallel load, 1 = shift
  input  logic [WIDTH-1:0] parallel_in,
  output logic             serial_out
);

  logic [WIDTH-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (!sel_p_s)       sr_d = parallel_in;
    else if (MSB_FIRST) sr_d = {sr_q[WIDTH-2:0], 1'b0};
    else                sr_d = {1'b0, sr_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst_n) sr_q <= '0;
    else       sr_q <= sr_d;
  end

  // Output taken straight from a flop so nothing combinational reaches the pin.
  assign serial_out = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];

endmodule

// File: tb/tb_piso_8_bit.sv
// Bench for piso_8_bit: directed literal checks plus randomized traffic compared
// every cycle against a word/shift-count model, for both shift directions.
module tb_piso_8_bit;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         sel_p_s = 1'b0;
  logic [W-1:0] parallel_in = '0;
  logic         so_m, so_l;

  int nchk = 0;
  int nfail = 0;

  // Model: last word captured and number of shifts since then.
  bit           known = 1'b0;
  logic [W-1:0] word = '0;
  int           k = 0;
  logic         exp_m, exp_l;

  piso_8_bit #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .sel_p_s(sel_p_s),
    .parallel_in(parallel_in), .serial_out(so_m));

  piso_8_bit #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .sel_p_s(sel_p_s),
    .parallel_in(parallel_in), .serial_out(so_l));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n) begin
      word = '0; k = 0; known = 1'b1;
    end else if (!sel_p_s) begin
      word = parallel_in; k = 0; known = 1'b1;
    end else if (k < W) begin
      k = k + 1;
    end
    exp_m = (k < W) ? word[W-1-k] : 1'b0;
    exp_l = (k < W) ? word[k]     : 1'b0;
  end

  always @(negedge clk) begin
    if (known) begin
      nchk++;
      if (so_m !== exp_m || so_l !== exp_l) begin
        nfail++;
        $display("FAIL cycle_cmp t=%0t: msb dut=%b model=%b, lsb dut=%b model=%b",
                 $time, so_m, exp_m, so_l, exp_l);
      end
    end
  end

  task automatic drive(input bit r, input bit s, input logic [W-1:0] p);
    @(negedge clk);
    rst_n = r; sel_p_s = s; parallel_in = p;
    @(posedge clk);
    #1;
  endtask

  // Literal expectation: pins both DUT and model for the MSB-first instance.
  task automatic chk(input string nm, input logic e);
    nchk++;
    if (so_m !== e || exp_m !== e) begin
      nfail++;
      $display("FAIL %s: dut=%b model=%b expected=%b", nm, so_m, exp_m, e);
    end
  endtask

  task automatic chk_l(input string nm, input logic e);
    nchk++;
    if (so_l !== e || exp_l !== e) begin
      nfail++;
      $display("FAIL %s: dut=%b model=%b expected=%b", nm, so_l, exp_l, e);
    end
  endtask

  initial begin
    logic [7:0] seq;
    logic [7:0] seq_l;

    drive(1, 0, 8'h00);  chk("reset_load00", 1'b0);
    drive(1, 1, 8'hFF);  chk("reset_shiftFF", 1'b0);
    chk_l("reset_lsb", 1'b0);

    // 0xBD, MSB first
    seq = 8'b01111010;
    drive(0, 0, 8'hBD);  chk("bd_load", 1'b1);
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, W'($urandom));
      chk($sformatf("bd_shift%0d", i + 1), seq[7-i]);
    end

    // 0x53, both directions
    seq   = 8'b10100110;
    seq_l = 8'b10010100;
    drive(0, 0, 8'h53);  chk("53_load", 1'b0);  chk_l("53_load_lsb", 1'b1);
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, W'($urandom));
      chk($sformatf("53_shift%0d", i + 1), seq[7-i]);
      chk_l($sformatf("53_lsb_shift%0d", i + 1), seq_l[7-i]);
    end

    // reload mid-shift
    drive(0, 0, 8'hBD);
    for (int i = 0; i < 3; i++) drive(0, 1, 8'h00);
    chk("reload_pre", 1'b1);
    drive(0, 0, 8'h80);  chk("reload_80", 1'b1);
    drive(0, 1, 8'hFF);  chk("reload_shift", 1'b0);

    // reset mid-shift
    drive(0, 0, 8'hFF);
    drive(0, 1, 8'h00);
    drive(0, 1, 8'h00);
    drive(1, 1, 8'hFF);  chk("rst_mid", 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 8'hFF);  chk($sformatf("rst_mid_shift%0d", i + 1), 1'b0);
    end

    // exhaustion
    drive(0, 0, 8'hFF);  chk("exh_load", 1'b1);
    for (int i = 1; i <= 10; i++) begin
      drive(0, 1, 8'hFF);
      chk($sformatf("exh_shift%0d", i), (i <= 7) ? 1'b1 : 1'b0);
    end

    // consecutive loads track parallel_in MSB
    for (int i = 0; i < 6; i++) begin
      logic [W-1:0] p;
      p = W'($urandom);
      drive(0, 0, p);
      chk($sformatf("hold_load%0d", i), p[W-1]);
    end

    // random traffic with mid-cycle input glitches
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      rst_n       = ($urandom_range(0, 29) == 0);
      sel_p_s     = ($urandom_range(0, 5) != 0);
      parallel_in = W'($urandom);
      @(posedge clk);
      #2;
      parallel_in = W'($urandom);
      sel_p_s     = $urandom_range(0, 1) == 1;
    end

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
